// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin front end that lets two requesters share one add/sub/mul/div calculator
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqX_valid / reqX_ready         request handshake for requester X (ready is combinational)
//   reqX_A, reqX_B, reqX_op         operands and opcode (00 add, 01 sub, 10 mul, 11 div)
//   rsp_valid / rsp_ready           response handshake
//   rsp_id, rsp_result, rsp_cout    owner, 2N-bit result and add/sub carry
//   rsp_dz, busy                    divide-by-zero flag, FSM not idle

module calc_arbiter_calc #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic [1:0]     op_i,
    output logic [2*N-1:0] result_o,
    output logic           c_out_o
);
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] quo;
    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        // Guarded so the divider never produces X; the arbiter overrides this case anyway.
        quo      = (b_i == '0) ? '1 : a_i / b_i;
        result_o = (op_i == 2'b00) ? {{N{1'b0}}, sum[N-1:0]} :
                   (op_i == 2'b01) ? {{N{1'b0}}, diff[N-1:0]} :
                   (op_i == 2'b10) ? {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i} :
                                     {{N{1'b0}}, quo};
        // Subtract carry is the inverse of the borrow, i.e. 1 when A >= B.
        c_out_o  = op_i[1] ? 1'b0 : (op_i[0] ? ~diff[N] : sum[N]);
    end
endmodule

module calc_arbiter #(
    parameter int N        = 8,
    parameter int MUL_WAIT = 2,
    parameter int DIV_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic           req1_valid,
    output logic           req0_ready,
    output logic           req1_ready,
    input  logic [N-1:0]   req0_A,
    input  logic [N-1:0]   req0_B,
    input  logic [N-1:0]   req1_A,
    input  logic [N-1:0]   req1_B,
    input  logic [1:0]     req0_op,
    input  logic [1:0]     req1_op,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_result,
    output logic           rsp_cout,
    output logic           rsp_dz,
    output logic           busy
);
    localparam int WMAX = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
    localparam int CW   = (WMAX < 1) ? 1 : $clog2(WMAX + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic           id_q, id_d, last_q, last_d;
    logic [2*N-1:0] res_q, res_d;
    logic           cout_q, cout_d, dz_q, dz_d;
    logic           grant, dz_now;
    logic [1:0]     op_sel;
    logic [2*N-1:0] calc_res;
    logic           calc_cout;

    calc_arbiter_calc #(.N(N)) u_calc (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (calc_res),
        .c_out_o  (calc_cout)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        req0_ready = (state_q == IDLE) && req0_valid && !grant;
        req1_ready = (state_q == IDLE) && req1_valid && grant;
        op_sel     = grant ? req1_op : req0_op;
        dz_now     = (op_q == 2'b11) && (b_q == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        last_d  = last_q;
        res_d   = res_q;
        cout_d  = cout_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (req0_ready || req1_ready) begin
                a_d     = grant ? req1_A : req0_A;
                b_d     = grant ? req1_B : req0_B;
                op_d    = op_sel;
                id_d    = grant;
                last_d  = grant;
                cnt_d   = (op_sel == 2'b10) ? CW'(MUL_WAIT) :
                          (op_sel == 2'b11) ? CW'(DIV_WAIT) : '0;
                state_d = EXEC;
            end
            EXEC: if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                res_d   = dz_now ? '1 : calc_res;
                cout_d  = dz_now ? 1'b0 : calc_cout;
                dz_d    = dz_now;
                state_d = DONE;
            end
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            res_q   <= '0;
            cout_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            dz_q    <= dz_d;
        end
    end

    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_cout   = cout_q;
    assign rsp_dz     = dz_q;
endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed bench for calc_arbiter with a transaction-level reference model
module tb_calc_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_A, req0_B, req1_A, req1_B;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_dz, busy;
    logic [15:0] rsp_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    calc_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_dz(rsp_dz), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected {dz, cout, result} straight from the arithmetic definition of each opcode.
    function automatic logic [17:0] expf(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [8:0]  s;
        logic [7:0]  d;
        logic [15:0] m;
        s = {1'b0, a} + {1'b0, b};
        d = a - b;
        m = a * b;
        case (op)
            2'd0:    return {1'b0, s[8], 8'h00, s[7:0]};
            2'd1:    return {1'b0, a >= b, 8'h00, d};
            2'd2:    return {2'b00, m};
            default: return (b == 8'd0) ? {2'b10, 16'hFFFF} : {2'b00, 8'h00, 8'(a / b)};
        endcase
    endfunction

    function automatic int wait_of(input logic [1:0] op);
        return (op == 2'd2) ? 2 : (op == 2'd3) ? 4 : 0;
    endfunction

    // Model: one transaction in flight at most; response visible from cycle m_due until handshaken.
    logic        m_inflight = 1'b0;
    logic        m_last = 1'b1;
    logic        m_id = 1'b0;
    logic [17:0] m_exp = '0;
    int          m_due = 0;

    function automatic logic mg();
        return (req0_valid && req1_valid) ? ~m_last : req1_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight <= 1'b0;
            m_last     <= 1'b1;
        end else if (!m_inflight) begin
            if (req0_valid || req1_valid) begin
                m_inflight <= 1'b1;
                m_last     <= mg();
                m_id       <= mg();
                m_exp      <= mg() ? expf(req1_A, req1_B, req1_op) : expf(req0_A, req0_B, req0_op);
                m_due      <= cyc + 2 + wait_of(mg() ? req1_op : req0_op);
            end
        end else if (cyc >= m_due && rsp_ready) begin
            m_inflight <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready0", req0_ready, !m_inflight && req0_valid && !mg());
            chk("ready1", req1_ready, !m_inflight && req1_valid && mg());
            chk("one_ready", req0_ready && req1_ready, 0);
            chk("busy", busy, m_inflight);
            chk("rsp_valid", rsp_valid, m_inflight && cyc >= m_due);
            if (m_inflight && cyc >= m_due)
                chk("rsp_fields", {rsp_id, rsp_dz, rsp_cout, rsp_result}, {m_id, m_exp});
        end
    end

    task automatic do_req(input int p, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input int w, input logic [15:0] er, input logic ec, input logic ed);
        int acc;
        bit seen;
        @(posedge clk); #1;
        if (p == 0) begin req0_valid = 1; req0_A = a; req0_B = b; req0_op = op; end
        else        begin req1_valid = 1; req1_A = a; req1_B = b; req1_op = op; end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (p == 0) ? req0_ready : req1_ready;
        end
        if (!seen) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        acc = cyc;
        // Scramble the request after acceptance; the in-flight result must not move.
        if (p == 0) begin req0_valid = 0; req0_A = ~a; req0_B = ~b; req0_op = ~op; end
        else        begin req1_valid = 0; req1_A = ~a; req1_B = ~b; req1_op = ~op; end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) chk("rsp_timeout", 0, 1);
        chk("latency", cyc - acc, w + 1);
        chk("lit_id", rsp_id, p);
        chk("lit_result", rsp_result, er);
        chk("lit_cout", rsp_cout, ec);
        chk("lit_dz", rsp_dz, ed);
    endtask

    task automatic chk_cleared(input string nm);
        chk(nm, {req0_ready, req1_ready, rsp_valid, busy, rsp_id, rsp_cout, rsp_dz, rsp_result}, 0);
    endtask

    initial begin
        int n;
        bit seen;
        logic seq [4];
        rst_n = 0; rsp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_A = 0; req0_B = 0; req1_A = 0; req1_B = 0; req0_op = 0; req1_op = 0;
        repeat (2) @(posedge clk);
        #1 chk_cleared("reset_state");
        rst_n = 1;

        do_req(0, 8'd200, 8'd100, 2'd0, 0, 16'h002C, 1'b1, 1'b0);
        do_req(1, 8'd5,   8'd7,   2'd1, 0, 16'h00FE, 1'b0, 1'b0);
        do_req(1, 8'd255, 8'd255, 2'd2, 2, 16'hFE01, 1'b0, 1'b0);
        do_req(0, 8'd100, 8'd7,   2'd3, 4, 16'h000E, 1'b0, 1'b0);
        do_req(0, 8'd9,   8'd0,   2'd3, 4, 16'hFFFF, 1'b0, 1'b1);
        do_req(1, 8'd7,   8'd7,   2'd1, 0, 16'h0000, 1'b1, 1'b0);
        do_req(0, 8'd3,   8'd4,   2'd0, 0, 16'h0007, 1'b0, 1'b0);

        // Both requesters valid from reset: grants must alternate starting with 0.
        @(posedge clk); #1;
        rst_n = 0;
        req0_valid = 1; req0_A = 8'd1; req0_B = 8'd1; req0_op = 2'd0;
        req1_valid = 1; req1_A = 8'd2; req1_B = 8'd2; req1_op = 2'd0;
        @(posedge clk); #1 rst_n = 1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin seq[n] = 0; n++; end
            else if (req1_ready) begin seq[n] = 1; n++; end
        end
        chk("rr_count", n, 4);
        chk("rr_seq", {seq[0], seq[1], seq[2], seq[3]}, 4'b0101);
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
        end
        if (!seen) chk("drain_timeout", 0, 1);

        // Back-pressure: response held for 3 cycles while requester 1 waits.
        @(posedge clk); #1;
        rsp_ready = 0;
        req0_valid = 1; req0_A = 8'd1; req0_B = 8'd2; req0_op = 2'd0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        if (!seen) chk("bp_ready_timeout", 0, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_A = 8'd10; req1_B = 8'd20; req1_op = 2'd0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) chk("bp_rsp_timeout", 0, 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold", {rsp_valid, busy, req1_ready, rsp_id, rsp_result}, {1'b1, 1'b1, 1'b0, 1'b0, 16'd3});
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        chk("bp_no_accept_in_done", req1_ready, 0);
        @(negedge clk);
        chk("bp_accept_resumes", {req1_ready, busy}, 2'b10);
        @(posedge clk); #1 req1_valid = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) chk("bp2_rsp_timeout", 0, 1);
        chk("bp2_result", {rsp_id, rsp_result}, {1'b1, 16'd30});

        // Reset pulse in the middle of a multiply aborts it.
        @(posedge clk); #1;
        req0_valid = 1; req0_A = 8'd3; req0_B = 8'd4; req0_op = 2'd2;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        if (!seen) chk("abort_ready_timeout", 0, 1);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk); #2 rst_n = 0;
        #1 chk_cleared("async_reset");
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("aborted_no_rsp", rsp_valid, 0);
        end
        do_req(0, 8'd3, 8'd4, 2'd2, 2, 16'h000C, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
